// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - sequencing controller for the 8-bit combinational ALU
// Registers operands onto the ALU, waits SETTLE_CYCLES, captures result/flags, returns them.
module alu_seq_ctrl #(
   parameter int SETTLE_CYCLES = 1,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_op,
   input  logic [7:0]       cmd_a,
   input  logic [7:0]       cmd_b,
   input  logic             cmd_use_acc,
   output logic [7:0]       alu_a,
   output logic [7:0]       alu_b,
   output logic [3:0]       alu_sel,
   input  logic [7:0]       alu_result,
   input  logic             alu_carry,
   input  logic             alu_zero,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [7:0]       rsp_data,
   output logic             rsp_carry,
   output logic             rsp_zero,
   output logic             rsp_err,
   output logic [7:0]       acc_out,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t     state, state_nxt;
   logic [3:0] settle;
   logic [7:0] acc;
   logic       accept;
   logic       op_legal;

   assign cmd_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);
   assign acc_out   = acc;
   assign accept    = cmd_valid && cmd_ready;
   assign op_legal  = (cmd_op <= 4'd8);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = op_legal ? EXEC : RESP;
         EXEC:    if (settle == 4'd0) state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a     <= 8'h00;
         alu_b     <= 8'h00;
         alu_sel   <= 4'h0;
         settle    <= 4'h0;
         acc       <= 8'h00;
         rsp_data  <= 8'h00;
         rsp_carry <= 1'b0;
         rsp_zero  <= 1'b0;
         rsp_err   <= 1'b0;
         op_count  <= '0;
      end else begin
         if (accept) begin
            alu_a   <= cmd_use_acc ? acc : cmd_a;
            alu_b   <= cmd_b;
            alu_sel <= cmd_op;
            settle  <= 4'(SETTLE_CYCLES - 1);
            // Illegal opcodes skip the ALU and answer with an error straight away.
            if (!op_legal) begin
               rsp_data  <= 8'h00;
               rsp_carry <= 1'b0;
               rsp_zero  <= 1'b0;
               rsp_err   <= 1'b1;
            end
         end
         if (state == EXEC) begin
            if (settle != 4'd0) begin
               settle <= settle - 4'd1;
            end else begin
               rsp_data  <= alu_result;
               rsp_carry <= alu_carry;
               rsp_zero  <= alu_zero;
               rsp_err   <= 1'b0;
               op_count  <= op_count + CNT_W'(1);
               if (alu_sel != 4'd8) acc <= alu_result;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - randomized self-checking bench for alu_seq_ctrl
// Drives a behavioural ALU from the DUT's ALU ports and compares responses with a reference model.
module tb_alu_seq_ctrl;

   localparam int SETTLE = 3;
   localparam int CW     = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [3:0]    cmd_op = 4'h0;
   logic [7:0]    cmd_a = 8'h00;
   logic [7:0]    cmd_b = 8'h00;
   logic          cmd_use_acc = 1'b0;
   logic [7:0]    alu_a, alu_b;
   logic [3:0]    alu_sel;
   logic [7:0]    alu_result;
   logic          alu_carry, alu_zero;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [7:0]    rsp_data;
   logic          rsp_carry, rsp_zero, rsp_err;
   logic [7:0]    acc_out;
   logic          busy;
   logic [CW-1:0] op_count;

   logic [7:0] acc_m;
   int         cnt_m;
   int         n_tests = 0;
   int         n_fail  = 0;
   logic [9:0] e;

   always #5 clk = ~clk;

   alu_seq_ctrl #(.SETTLE_CYCLES(SETTLE), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
      .acc_out(acc_out), .busy(busy), .op_count(op_count)
   );

   // Returns {carry, zero, result}; illegal selects produce junk that must never be captured.
   function automatic logic [9:0] alu_f(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
      logic [8:0] w;
      logic [7:0] r;
      logic       c;
      c = 1'b0;
      r = 8'h00;
      w = 9'h000;
      case (s)
         4'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8]; end
         4'd1, 4'd8: begin r = a - b; c = (a < b); end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         4'd5: r = ~a;
         4'd6: begin w = {1'b0, a} + 9'd1; r = w[7:0]; c = w[8]; end
         4'd7: begin r = a - 8'd1; c = (a == 8'd0); end
         default: begin r = 8'hEE; c = 1'b1; end
      endcase
      return {c, (r == 8'h00), r};
   endfunction

   always_comb {alu_carry, alu_zero, alu_result} = alu_f(alu_sel, alu_a, alu_b);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge in IDLE; returns at the first negedge with rsp_valid seen.
   task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic ua, output logic [9:0] ex);
      logic [7:0] ae;
      logic       legal;
      int         n;
      ae    = ua ? acc_m : a;
      legal = (op <= 4'd8);
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("alu_a", alu_a, ae);
      check("alu_b", alu_b, b);
      check("alu_sel", alu_sel, op);
      check("busy", busy, 1);
      n = 0;
      while (!rsp_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("latency", n, legal ? SETTLE : 0);
      ex = legal ? alu_f(op, ae, b) : 10'h000;
      check("rsp_data", rsp_data, ex[7:0]);
      check("rsp_zero", rsp_zero, ex[8]);
      check("rsp_carry", rsp_carry, ex[9]);
      check("rsp_err", rsp_err, !legal);
      check("cmd_ready_busy", cmd_ready, 0);
      if (legal) begin
         if (op != 4'd8) acc_m = ex[7:0];
         cnt_m = (cnt_m + 1) % (1 << CW);
      end
   endtask

   task automatic hold_rsp(input int cycles, input logic [7:0] d, input logic [3:0] sel);
      repeat (cycles) begin
         @(negedge clk);
         check("hold_valid", rsp_valid, 1);
         check("hold_data", rsp_data, d);
         check("hold_ready", cmd_ready, 0);
         check("hold_sel", alu_sel, sel);
      end
   endtask

   task automatic release_rsp();
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      check("rel_valid", rsp_valid, 0);
      check("rel_ready", cmd_ready, 1);
      check("acc_out", acc_out, acc_m);
      check("op_count", op_count, cnt_m);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      acc_m = 8'h00;
      cnt_m = 0;
      repeat (2) @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_alu", {alu_a, alu_b, alu_sel}, 0);
      check("rst_rsp", {rsp_data, rsp_carry, rsp_zero, rsp_err}, 0);
      check("rst_acc_cnt", {acc_out, op_count, busy}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      send(4'd0, 8'hFF, 8'h01, 1'b0, e);
      check("add_ff_data", rsp_data, 8'h00);
      check("add_ff_flags", {rsp_carry, rsp_zero}, 2'b11);
      release_rsp();

      send(4'd0, 8'h10, 8'h05, 1'b0, e);
      release_rsp();
      send(4'd1, 8'h99, 8'h03, 1'b1, e);
      check("chain_sub_data", rsp_data, 8'h12);
      release_rsp();
      check("chain_acc", acc_out, 8'h12);
      send(4'd8, 8'h00, 8'h12, 1'b1, e);
      check("cmp_zero", rsp_zero, 1);
      release_rsp();
      check("cmp_acc_kept", acc_out, 8'h12);

      send(4'hA, 8'h55, 8'h00, 1'b0, e);
      release_rsp();

      send(4'd4, 8'hF0, 8'h3C, 1'b0, e);
      check("xor_data", rsp_data, 8'hCC);
      cmd_valid = 1'b1; cmd_op = 4'd2; cmd_a = 8'h0F; cmd_b = 8'h3C; cmd_use_acc = 1'b0;
      hold_rsp(6, 8'hCC, 4'd4);
      release_rsp();
      check("pending_not_taken", alu_sel, 4'd4);
      send(4'd2, 8'h0F, 8'h3C, 1'b0, e);
      release_rsp();

      for (int i = 0; i < 40; i++) begin
         logic [3:0] op;
         op = 4'($urandom_range(0, 15));
         send(op, 8'($urandom), 8'($urandom), 1'($urandom), e);
         hold_rsp($urandom_range(0, 3), e[7:0], op);
         release_rsp();
      end

      cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = 8'h01; cmd_b = 8'h02; cmd_use_acc = 1'b0;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_ready", cmd_ready, 1);
      check("mid_rst_out", {alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_carry, rsp_zero, rsp_err}, 0);
      check("mid_rst_acc", {acc_out, op_count, busy}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      acc_m = 8'h00;
      cnt_m = 0;
      repeat (SETTLE + 3) begin
         @(negedge clk);
         check("no_rsp_after_rst", {rsp_valid, cmd_ready}, 2'b01);
      end
      check("op_count_after_rst", op_count, 0);

      for (int i = 0; i < 17; i++) begin
         send(4'd6, 8'($urandom), 8'h00, 1'b0, e);
         release_rsp();
         if (i == 15) check("wrap_to_0", op_count, 0);
         if (i == 16) check("wrap_to_1", op_count, 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
